// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared widths, moduli and wrap-add helper for the watch datapath
package watch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [7:0] MSEC_N = 8'd100;
    localparam logic [7:0] SEC_N  = 8'd60;
    localparam logic [7:0] MIN_N  = 8'd60;
    localparam logic [7:0] HOUR_N = 8'd24;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    // amt is at most 2 and v at most n-1, so one conditional subtract is enough
    function automatic logic [7:0] wrap_add(input logic [7:0] v, input logic [1:0] amt,
                                            input logic [7:0] n);
        logic [7:0] w_sum;
        w_sum = v + {6'b0, amt};
        return (w_sum >= n) ? w_sum - n : w_sum;
    endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// rtl/watch_tick_gen.sv - divides clk down to a one-cycle strobe every CLK_FREQ_HZ/TICK_HZ clocks
module watch_tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/watch_dp.sv
// rtl/watch_dp.sv - time-of-day counters advanced by the tick chain and by set edges from watch_cu
module watch_dp
    import watch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int INIT_HOUR   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sec_plus,
    input  logic              i_min_plus,
    input  logic              i_hour_plus,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    logic              w_tick;
    logic              r_sec_d, r_min_d, r_hour_d;
    logic [MSEC_W-1:0] r_msec;
    logic [SEC_W-1:0]  r_sec;
    logic [MIN_W-1:0]  r_min;
    logic [HOUR_W-1:0] r_hour;

    logic       w_sec_edge, w_min_edge, w_hour_edge;
    logic       w_msec_co, w_sec_co, w_min_co;
    logic [1:0] w_msec_amt, w_sec_amt, w_min_amt, w_hour_amt;

    watch_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_sec_edge  = i_sec_plus  & ~r_sec_d;
    assign w_min_edge  = i_min_plus  & ~r_min_d;
    assign w_hour_edge = i_hour_plus & ~r_hour_d;

    // Carries come only from the tick chain; a set edge never ripples upward
    assign w_msec_co = w_tick    & (r_msec == MSEC_MAX);
    assign w_sec_co  = w_msec_co & (r_sec  == SEC_MAX);
    assign w_min_co  = w_sec_co  & (r_min  == MIN_MAX);

    assign w_msec_amt = {1'b0, w_tick};
    assign w_sec_amt  = {1'b0, w_msec_co} + {1'b0, w_sec_edge};
    assign w_min_amt  = {1'b0, w_sec_co}  + {1'b0, w_min_edge};
    assign w_hour_amt = {1'b0, w_min_co}  + {1'b0, w_hour_edge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_d  <= 1'b0;
            r_min_d  <= 1'b0;
            r_hour_d <= 1'b0;
        end else begin
            r_sec_d  <= i_sec_plus;
            r_min_d  <= i_min_plus;
            r_hour_d <= i_hour_plus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_msec <= '0;
        else     r_msec <= MSEC_W'(wrap_add(8'(r_msec), w_msec_amt, MSEC_N));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sec <= '0;
        else     r_sec <= SEC_W'(wrap_add(8'(r_sec), w_sec_amt, SEC_N));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_min <= '0;
        else     r_min <= MIN_W'(wrap_add(8'(r_min), w_min_amt, MIN_N));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hour <= HOUR_W'(INIT_HOUR);
        else     r_hour <= HOUR_W'(wrap_add(8'(r_hour), w_hour_amt, HOUR_N));
    end

    assign o_msec = r_msec;
    assign o_sec  = r_sec;
    assign o_min  = r_min;
    assign o_hour = r_hour;
    assign o_tick = w_tick;

endmodule

// File: tb/tb_watch_dp.sv
// tb/tb_watch_dp.sv - directed scoreboard bench for watch_dp at DIV=10
module tb_watch_dp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_sec_plus = 1'b0;
    logic       i_min_plus = 1'b0;
    logic       i_hour_plus = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    int checks = 0;
    int failures = 0;
    int cyc;

    typedef struct {
        string tag;
        int    h;
        int    m;
        int    s;
        int    ms;
    } exp_t;

    exp_t sb[$];

    watch_dp #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100),
        .INIT_HOUR   (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sec_plus  (i_sec_plus),
        .i_min_plus  (i_min_plus),
        .i_hour_plus (i_hour_plus),
        .o_msec      (o_msec),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_tick      (o_tick)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the k-th tick is applied on posedge 10k+1
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input int h, input int m, input int s, input int ms);
        exp_t e;
        e.tag = tag; e.h = h; e.m = m; e.s = s; e.ms = ms;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, "_hour"}, 32'(o_hour), 32'(e.h));
            check_val({e.tag, "_min"},  32'(o_min),  32'(e.m));
            check_val({e.tag, "_sec"},  32'(o_sec),  32'(e.s));
            check_val({e.tag, "_msec"}, 32'(o_msec), 32'(e.ms));
        end
    endtask

    task automatic wait_cyc(input string tag, input int target);
        int guard = 0;
        while (cyc != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_val({"wait_", tag}, 32'(cyc), 32'(target));
    endtask

    task automatic do_reset();
        i_sec_plus = 1'b0; i_min_plus = 1'b0; i_hour_plus = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            case (which)
                0: i_sec_plus = 1'b1;
                1: i_min_plus = 1'b1;
                default: i_hour_plus = 1'b1;
            endcase
            @(negedge clk);
            i_sec_plus = 1'b0; i_min_plus = 1'b0; i_hour_plus = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state while rst is held
        @(negedge clk);
        @(negedge clk);
        push_exp("reset", 12, 0, 0, 0);
        check_pop();
        check_val("reset_tick", 32'(o_tick), 32'd0);

        // 1: first tick after 10 clocks, one cycle wide, period 10; 100 ticks -> 1 s
        rst = 1'b0;
        wait_cyc("t1_c9", 9);
        check_val("t1_tick_c9", 32'(o_tick), 32'd0);
        @(negedge clk);
        check_val("t1_tick_c10", 32'(o_tick), 32'd1);
        @(negedge clk);
        check_val("t1_tick_c11", 32'(o_tick), 32'd0);
        wait_cyc("t1_c19", 19);
        check_val("t1_tick_c19", 32'(o_tick), 32'd0);
        @(negedge clk);
        check_val("t1_tick_c20", 32'(o_tick), 32'd1);
        wait_cyc("t1_c1001", 1001);
        push_exp("t1_100ticks", 12, 0, 1, 0);
        check_pop();

        // 2: preload 23:59:59.99 then one tick rolls everything over
        do_reset();
        pulse(2, 11);
        pulse(1, 59);
        pulse(0, 59);
        wait_cyc("t2_c1000", 1000);
        push_exp("t2_preload", 23, 59, 59, 99);
        check_pop();
        @(negedge clk);
        push_exp("t2_rollover", 0, 0, 0, 0);
        check_pop();
        wait_cyc("t2_c1011", 1011);
        push_exp("t2_after", 0, 0, 0, 1);
        check_pop();

        // 3: holding min_plus gives a single increment, no carry into hour
        do_reset();
        pulse(1, 59);
        push_exp("t3_min59", 12, 59, 0, 11);
        check_pop();
        i_min_plus = 1'b1;
        repeat (50) @(negedge clk);
        i_min_plus = 1'b0;
        push_exp("t3_hold", 12, 0, 0, 16);
        check_pop();

        // 4a: set edge coinciding with msec carry, sec=58 -> 0 without carry
        do_reset();
        pulse(0, 58);
        wait_cyc("t4a_c1000", 1000);
        push_exp("t4a_pre", 12, 0, 58, 99);
        check_pop();
        i_sec_plus = 1'b1;
        @(negedge clk);
        i_sec_plus = 1'b0;
        push_exp("t4a_post", 12, 0, 0, 0);
        check_pop();

        // 4b: same with sec=59 -> 1 and carry into min
        do_reset();
        pulse(0, 59);
        wait_cyc("t4b_c1000", 1000);
        i_sec_plus = 1'b1;
        @(negedge clk);
        i_sec_plus = 1'b0;
        push_exp("t4b_post", 12, 1, 1, 0);
        check_pop();

        // 5: three set inputs at once
        do_reset();
        i_sec_plus = 1'b1; i_min_plus = 1'b1; i_hour_plus = 1'b1;
        @(negedge clk);
        i_sec_plus = 1'b0; i_min_plus = 1'b0; i_hour_plus = 1'b0;
        push_exp("t5_all", 13, 1, 1, 0);
        check_pop();

        // 6: async reset mid-count, then first tick exactly 10 clocks after release
        do_reset();
        pulse(0, 30);
        wait_cyc("t6_c65", 65);
        push_exp("t6_pre", 12, 0, 30, 6);
        check_pop();
        #1;
        rst = 1'b1;
        #1;
        push_exp("t6_async", 12, 0, 0, 0);
        check_pop();
        check_val("t6_async_tick", 32'(o_tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc("t6_c9", 9);
        check_val("t6_tick_c9", 32'(o_tick), 32'd0);
        @(negedge clk);
        check_val("t6_tick_c10", 32'(o_tick), 32'd1);
        @(negedge clk);
        check_val("t6_tick_c11", 32'(o_tick), 32'd0);
        push_exp("t6_first_tick", 12, 0, 0, 1);
        check_pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
